// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of arbitrary depth with occupancy count,
// programmable almost-full/almost-empty watermarks, synchronous flush and
// sticky overflow/underflow flags. value_o shows the head entry (show-ahead).
//
// Handshake: an enqueue is taken when enqueue_en is high and the FIFO is not
// full, or is full but dequeue_en is also high. A dequeue is taken when
// dequeue_en is high and the FIFO is not empty. flush_en (and reset) override
// both, so nothing is taken and no error flag is set in that cycle.
module sync_fifo #(
   parameter int WIDTH                  = 32,
   parameter int SIZE                   = 8,
   parameter int ALMOST_FULL_THRESHOLD  = SIZE,
   parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush_en,
   input  logic                      enqueue_en,
   input  logic [WIDTH-1:0]          value_i,
   input  logic                      dequeue_en,
   output logic [WIDTH-1:0]          value_o,
   output logic [$clog2(SIZE+1)-1:0] count,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int CW = $clog2(SIZE + 1);

   localparam logic [PW-1:0] LAST_PTR = PW'(SIZE - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(SIZE);
   localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_THRESHOLD);
   localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_THRESHOLD);

   // Storage starts at zero and is never cleared by reset or flush.
   logic [WIDTH-1:0] mem [SIZE] = '{default: '0};

   logic [PW-1:0] read_ptr;
   logic [PW-1:0] write_ptr;
   logic [PW-1:0] read_ptr_next;
   logic [PW-1:0] write_ptr_next;
   logic [CW-1:0] count_next;
   logic          acc_enq;
   logic          acc_deq;
   logic          ovf_set;
   logic          unf_set;

   // Head entry is read straight from the pointer; undefined content while empty.
   assign value_o = mem[read_ptr];

   // Accept/error decisions for this cycle; flush suppresses everything.
   always_comb begin
      acc_enq = enqueue_en && (!full || dequeue_en) && !flush_en;
      acc_deq = dequeue_en && !empty && !flush_en;
      ovf_set = enqueue_en && full && !dequeue_en && !flush_en;
      unf_set = dequeue_en && empty && !flush_en;
   end

   // Next pointers wrap by explicit compare so SIZE need not be a power of two.
   always_comb begin
      read_ptr_next  = read_ptr;
      write_ptr_next = write_ptr;
      if (acc_deq) begin
         read_ptr_next = (read_ptr == LAST_PTR) ? '0 : read_ptr + PW'(1);
      end
      if (acc_enq) begin
         write_ptr_next = (write_ptr == LAST_PTR) ? '0 : write_ptr + PW'(1);
      end
   end

   // Occupancy after this cycle's accepted operations.
   always_comb begin
      count_next = count;
      if (acc_enq && !acc_deq) begin
         count_next = count + CW'(1);
      end else if (acc_deq && !acc_enq) begin
         count_next = count - CW'(1);
      end
   end

   // Write the accepted entry; reset discards any write in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset && acc_enq) begin
         mem[write_ptr] <= value_i;
      end
   end

   // Pointers, count and registered status flags; reset and flush look the same.
   always_ff @(posedge clk) begin
      if (reset || flush_en) begin
         read_ptr     <= '0;
         write_ptr    <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         read_ptr     <= read_ptr_next;
         write_ptr    <= write_ptr_next;
         count        <= count_next;
         full         <= (count_next == FULL_CNT);
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= AF_CNT);
         almost_empty <= (count_next <= AE_CNT);
         overflow     <= overflow | ovf_set;
         underflow    <= underflow | unf_set;
      end
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO for same-domain buffering. It supports arbitrary depth (not only powers of two), programmable almost-full/almost-empty watermarks, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. Typical uses are request queues in the L2 and memory interface, where back-pressure is driven from the watermarks.

## Interface
- WIDTH, 32, data width in bits
- SIZE, 8, number of entries; any integer >= 2
- ALMOST_FULL_THRESHOLD, SIZE, almost_full asserts when count >= this; range 1..SIZE
- ALMOST_EMPTY_THRESHOLD, 1, almost_empty asserts when count <= this; range 0..SIZE-1
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- flush_en  in  1  discard all contents this cycle
- enqueue_en  in  1  write value_i this cycle
- value_i  in  WIDTH  write data
- dequeue_en  in  1  pop head entry this cycle
- value_o  out  WIDTH  head entry (show-ahead)
- count  out  $clog2(SIZE+1)  current occupancy
- full  out  1  count == SIZE
- empty  out  1  count == 0
- almost_full  out  1  count >= ALMOST_FULL_THRESHOLD
- almost_empty  out  1  count <= ALMOST_EMPTY_THRESHOLD
- overflow  out  1  sticky: an enqueue was dropped
- underflow  out  1  sticky: a dequeue was issued while empty

## Operation
- Storage is SIZE x WIDTH. It is zero-initialised at time zero and is not cleared by reset or flush.
- Read and write pointers have width $clog2(SIZE) and wrap from SIZE-1 to 0 by explicit compare. There is no reliance on power-of-two rollover.
- value_o = storage[read_ptr], combinational from the pointer. value_o is undefined whenever empty = 1.
- Accepted enqueue = enqueue_en && (!full || dequeue_en) && !flush_en. It writes value_i at write_ptr and advances write_ptr.
- Accepted dequeue = dequeue_en && !empty && !flush_en. It advances read_ptr.
- count_next = count + accepted_enqueue - accepted_dequeue.
- When full, a simultaneous enqueue and dequeue are both accepted; count stays SIZE.
- When empty, a simultaneous enqueue and dequeue accept only the enqueue; count becomes 1 and underflow sets.
- overflow sets on enqueue_en && full && !dequeue_en && !flush_en.
- underflow sets on dequeue_en && empty && !flush_en.
- Both error flags hold until reset or flush.
- Flush: pointers go to 0, count goes to 0, and both error flags clear. Any enqueue or dequeue in the same cycle is ignored and sets no error.
- Priority: reset > flush_en > enqueue/dequeue.

## Timing
- All outputs except value_o are registered. They reflect count_next one rising edge after the inputs that caused it; there is no combinational path from any input to any output.
- Enqueue-to-visible latency is 1 cycle: data written on edge N appears on value_o after edge N when the FIFO was empty, and empty deasserts at the same time.
- Dequeue takes effect at the edge. The next entry appears on value_o after that edge.
- Reset values: count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0, read_ptr = write_ptr = 0.
- Reset asserted mid-stream discards all contents at the next edge, with the same result as flush.
- Status flags are computed from count_next, so full, empty and the watermarks are always mutually consistent with count in the same cycle.

## Test plan
- SIZE=5, WIDTH=8: after reset, enqueue 0x01..0x05 on consecutive cycles -> count 1..5; full = 1 after the 5th edge; value_o = 0x01 throughout. Then dequeue 5 times -> value_o sequence 0x02..0x05; empty = 1 after the 5th pop.
- SIZE=5: perform 13 enqueue/dequeue pairs at count = 2 -> pointers wrap past 4 to 0; output order is preserved with no loss; count stays 2.
- Full FIFO: enqueue_en alone -> overflow = 1, count 5, contents unchanged. Full FIFO, enqueue_en with dequeue_en -> both accepted, count 5, new tail = value_i, overflow unchanged.
- Empty FIFO: dequeue_en alone -> underflow = 1, count 0. Empty FIFO, enqueue 0xAA with dequeue_en -> count 1, value_o = 0xAA, underflow = 1.
- ALMOST_FULL_THRESHOLD=4, ALMOST_EMPTY_THRESHOLD=1: fill then drain -> almost_full is 1 exactly for count 4..5; almost_empty is 1 exactly for count 0..1.
- At count = 3 with overflow set, assert flush_en together with enqueue_en -> next cycle count 0, empty 1, overflow 0, and the enqueued value is not stored. Repeating the sequence with reset in place of flush_en gives identical results.
